// File: rtl/execute_md_pkg.sv
// Shared pipeline types for the execute stage: operand-source select, ALU ops,
// M-extension funct3 codes and the DE->EX / EX->MEM stage registers.
package riscv_structures;

    // XLEN_DEF also sets the width of the stage-register structs below.
    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_e;

    typedef enum logic [1:0] {SRC_REG, SRC_MEM, SRC_WB} hu_src_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic                v_de;
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] rs1_data;
        logic [XLEN_DEF-1:0] rs2_data;
        logic [XLEN_DEF-1:0] imm;
        alu_op_e             alu_op;
        logic                use_pc;
        logic                use_imm;
        logic                is_jump;
        logic                mem_write;
        logic                reg_write;
        logic                is_md;
        logic [2:0]          funct3;
        logic [4:0]          rd;
    } de_to_ex_s;

    typedef struct packed {
        logic [XLEN_DEF-1:0] alu_result;
        logic [XLEN_DEF-1:0] write_data;
        logic [4:0]          rd;
        logic [2:0]          funct3;
        logic                mem_write;
        logic                reg_write;
    } ex_to_mem_s;

endpackage

// File: rtl/execute_md_md_unit.sv
// Iterative multiply/divide: radix-2 shift-add multiply, restoring divide,
// on operand magnitudes with sign correction applied to the final result.
//   state | meaning
//   IDLE  | waiting for start; operands latched on the accepting edge
//   RUN   | one shift-add / shift-subtract step per cycle
//   DONE  | result valid for one cycle, then back to IDLE
module md_unit
    import riscv_structures::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_q
);
    localparam int CW = $clog2(XLEN);

    md_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   addend_q, dvd_q;
    logic [2:0]        f3_q;
    logic              neg_res_q, neg_rem_q, div0_q, ovf_q;

    logic              is_div, a_sgn, b_sgn, accept;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_trial, div_diff;
    logic [2*XLEN-1:0] mul_step, div_step, prod;
    logic [XLEN-1:0]   q_mag, r_mag, quo, rem;

    assign is_div = funct3[2];
    assign a_sgn  = op_a[XLEN-1] && (is_div ? !funct3[0] : (funct3 == F3_MULH || funct3 == F3_MULHSU));
    assign b_sgn  = op_b[XLEN-1] && (is_div ? !funct3[0] : (funct3 == F3_MULH));
    assign a_mag  = a_sgn ? -op_a : op_a;
    assign b_mag  = b_sgn ? -op_b : op_b;
    assign accept = (state_q == IDLE) && start && !flush;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, addend_q} : '0);
    assign mul_step  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_trial - {1'b0, addend_q};
    assign div_step  = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            addend_q  <= '0;
            dvd_q     <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q     <= CW'(XLEN - 1);
                acc_q     <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                addend_q  <= is_div ? b_mag : a_mag;
                dvd_q     <= op_a;
                f3_q      <= funct3;
                rd_q      <= rd;
                neg_res_q <= a_sgn ^ b_sgn;
                neg_rem_q <= a_sgn;
                div0_q    <= is_div && (op_b == '0);
                ovf_q     <= is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
            end else if (state_q == RUN) begin
                acc_q <= f3_q[2] ? div_step : mul_step;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (div0_q || ovf_q || cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    assign busy = accept || (state_q == RUN);
    assign done = (state_q == DONE);

    assign prod  = neg_res_q ? -acc_q : acc_q;
    assign q_mag = acc_q[XLEN-1:0];
    assign r_mag = acc_q[2*XLEN-1:XLEN];
    assign quo   = neg_res_q ? -q_mag : q_mag;
    assign rem   = neg_rem_q ? -r_mag : r_mag;

    always_comb begin
        result = '0;
        case (f3_q)
            F3_MUL:                       result = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result = div0_q ? '1 : (ovf_q ? dvd_q : quo);
            F3_REM, F3_REMU:              result = div0_q ? dvd_q : (ovf_q ? '0 : rem);
            default:                      result = '0;
        endcase
    end

endmodule

// File: rtl/execute_md.sv
// Execute stage with operand bypass, ALU, branch compare and an optional
// iterative M-extension unit that stalls the pipe while it runs.
module execute_md
    import riscv_structures::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int MD_ENABLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  de_to_ex_s       de_to_ex,
    input  hu_src_e         rs1s,
    input  hu_src_e         rs2s,
    input  logic [XLEN-1:0] bp_mem,
    input  logic [XLEN-1:0] bp_wb,
    input  logic            flush,
    output ex_to_mem_s      ex_to_mem,
    output logic            pc_reset,
    output logic [XLEN-1:0] pc_exec,
    output logic            ex_busy
);
    logic [XLEN-1:0]         rs1_val, rs2_val, alu_a, alu_b, alu_res, md_result;
    logic [$clog2(XLEN)-1:0] shamt;
    logic                    cmp, md_start, md_busy, md_done;
    logic [4:0]              md_rd;

    always_comb begin
        case (rs1s)
            SRC_MEM: rs1_val = bp_mem;
            SRC_WB:  rs1_val = bp_wb;
            default: rs1_val = de_to_ex.rs1_data;
        endcase
        case (rs2s)
            SRC_MEM: rs2_val = bp_mem;
            SRC_WB:  rs2_val = bp_wb;
            default: rs2_val = de_to_ex.rs2_data;
        endcase
    end

    assign alu_a = de_to_ex.use_pc  ? de_to_ex.pc  : rs1_val;
    assign alu_b = de_to_ex.use_imm ? de_to_ex.imm : rs2_val;
    assign shamt = alu_b[$clog2(XLEN)-1:0];

    always_comb begin
        alu_res = '0;
        case (de_to_ex.alu_op)
            ALU_ADD:  alu_res = alu_a + alu_b;
            ALU_SUB:  alu_res = alu_a - alu_b;
            ALU_AND:  alu_res = alu_a & alu_b;
            ALU_OR:   alu_res = alu_a | alu_b;
            ALU_XOR:  alu_res = alu_a ^ alu_b;
            ALU_SLL:  alu_res = alu_a << shamt;
            ALU_SRL:  alu_res = alu_a >> shamt;
            ALU_SRA:  alu_res = XLEN'($signed(alu_a) >>> shamt);
            ALU_SLT:  alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
            ALU_SLTU: alu_res = XLEN'(alu_a < alu_b);
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        cmp = 1'b0;
        case (de_to_ex.funct3)
            F3_BEQ:  cmp = (rs1_val == rs2_val);
            F3_BNE:  cmp = (rs1_val != rs2_val);
            F3_BLT:  cmp = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  cmp = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: cmp = (rs1_val <  rs2_val);
            F3_BGEU: cmp = (rs1_val >= rs2_val);
            default: cmp = 1'b0;
        endcase
    end

    assign pc_reset = de_to_ex.v_de && !flush && !rst &&
                      ((cmp && de_to_ex.use_pc) || de_to_ex.is_jump);
    assign pc_exec  = alu_res;

    assign md_start = (MD_ENABLE != 0) && de_to_ex.v_de && de_to_ex.is_md && !flush;

    generate
        if (MD_ENABLE != 0) begin : g_md
            md_unit #(.XLEN(XLEN)) u_md_unit (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush),
                .start  (md_start),
                .op_a   (rs1_val),
                .op_b   (rs2_val),
                .funct3 (de_to_ex.funct3),
                .rd     (de_to_ex.rd),
                .busy   (md_busy),
                .done   (md_done),
                .result (md_result),
                .rd_q   (md_rd)
            );
        end else begin : g_no_md
            assign md_busy   = 1'b0;
            assign md_done   = 1'b0;
            assign md_result = '0;
            assign md_rd     = '0;
        end
    endgenerate

    assign ex_busy = md_busy && !rst;

    // A flush or an in-flight M op leaves an all-zero bubble in the MEM register.
    always_ff @(posedge clk) begin
        if (rst || flush || ex_busy) begin
            ex_to_mem <= '0;
        end else if (md_done) begin
            ex_to_mem            <= '0;
            ex_to_mem.alu_result <= md_result;
            ex_to_mem.rd         <= md_rd;
            ex_to_mem.funct3     <= de_to_ex.funct3;
            ex_to_mem.reg_write  <= 1'b1;
        end else begin
            ex_to_mem.alu_result <= de_to_ex.is_jump ? de_to_ex.pc + XLEN'(4) : alu_res;
            ex_to_mem.write_data <= rs2_val;
            ex_to_mem.rd         <= de_to_ex.rd;
            ex_to_mem.funct3     <= de_to_ex.funct3;
            ex_to_mem.mem_write  <= de_to_ex.mem_write && de_to_ex.v_de;
            ex_to_mem.reg_write  <= de_to_ex.reg_write && de_to_ex.v_de;
        end
    end

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: bypass/ALU path, branch redirect, and the
// iterative multiply/divide with flush and reset interruptions.
module tb_execute_md;
    import riscv_structures::*;

    logic        clk = 1'b0;
    logic        rst;
    de_to_ex_s   de;
    hu_src_e     rs1s, rs2s;
    logic [31:0] bp_mem, bp_wb;
    logic        flush;
    ex_to_mem_s  ex_to_mem;
    logic        pc_reset;
    logic [31:0] pc_exec;
    logic        ex_busy;

    int total = 0;
    int bad   = 0;

    execute_md #(.XLEN(32), .MD_ENABLE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .de_to_ex  (de),
        .rs1s      (rs1s),
        .rs2s      (rs2s),
        .bp_mem    (bp_mem),
        .bp_wb     (bp_wb),
        .flush     (flush),
        .ex_to_mem (ex_to_mem),
        .pc_reset  (pc_reset),
        .pc_exec   (pc_exec),
        .ex_busy   (ex_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Operand a arrives via the MEM bypass and is scrambled after the accept edge.
    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
        int   n;
        logic bub_bad;
        de          = '0;
        de.v_de     = 1'b1;
        de.is_md    = 1'b1;
        de.funct3   = f3;
        de.rd       = 5'd9;
        de.reg_write = 1'b1;
        de.rs1_data = 32'hDEAD_BEEF;
        de.rs2_data = b;
        rs1s        = SRC_MEM;
        rs2s        = SRC_REG;
        bp_mem      = a;
        #1;
        n       = 0;
        bub_bad = 1'b0;
        while (ex_busy && n < 200) begin
            tick();
            n++;
            bp_mem = ~a;
            if (ex_to_mem.reg_write || ex_to_mem.mem_write) bub_bad = 1'b1;
        end
        chk({tag, " busy_cycles"}, 64'(n), 64'(exp_cyc));
        chk({tag, " bubble"}, 64'(bub_bad), 64'd0);
        tick();
        chk({tag, " result"}, 64'(ex_to_mem.alu_result), 64'(exp));
        chk({tag, " rd/wr"}, {ex_to_mem.rd, ex_to_mem.reg_write, ex_to_mem.mem_write},
            {5'd9, 1'b1, 1'b0});
        de.v_de = 1'b0;
        rs1s    = SRC_REG;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic wr_seen;

        // Reset with a valid jump + M op on the input: outputs must stay quiet.
        rst         = 1'b1;
        flush       = 1'b0;
        rs1s        = SRC_REG;
        rs2s        = SRC_REG;
        bp_mem      = '0;
        bp_wb       = '0;
        de          = '0;
        de.v_de     = 1'b1;
        de.is_jump  = 1'b1;
        de.is_md    = 1'b1;
        de.reg_write = 1'b1;
        de.rs1_data = 32'd3;
        de.rs2_data = 32'd4;
        tick();
        tick();
        chk("rst pc_reset", 64'(pc_reset), 64'd0);
        chk("rst ex_busy", 64'(ex_busy), 64'd0);
        chk("rst alu_result", 64'(ex_to_mem.alu_result), 64'd0);
        chk("rst write_data", 64'(ex_to_mem.write_data), 64'd0);
        chk("rst ctrl", {ex_to_mem.rd, ex_to_mem.funct3, ex_to_mem.mem_write, ex_to_mem.reg_write}, 64'd0);
        rst = 1'b0;
        de  = '0;
        tick();

        // ADD x3 with rs1 taken from the MEM bypass.
        de           = '0;
        de.v_de      = 1'b1;
        de.alu_op    = ALU_ADD;
        de.rs1_data  = 32'd5;
        de.rs2_data  = 32'd7;
        de.rd        = 5'd3;
        de.reg_write = 1'b1;
        rs1s         = SRC_MEM;
        bp_mem       = 32'd10;
        #1;
        chk("add ex_busy", 64'(ex_busy), 64'd0);
        tick();
        chk("add result", 64'(ex_to_mem.alu_result), 64'd17);
        chk("add write_data", 64'(ex_to_mem.write_data), 64'd7);
        chk("add rd/wr", {ex_to_mem.rd, ex_to_mem.reg_write}, {5'd3, 1'b1});
        rs1s = SRC_REG;

        // SUB with rs2 from WB, immediate-free.
        de.alu_op = ALU_SUB;
        rs2s      = SRC_WB;
        bp_wb     = 32'd8;
        tick();
        chk("sub result", 64'(ex_to_mem.alu_result), 64'hFFFF_FFFD);
        rs2s = SRC_REG;

        // BEQ, equal via WB bypass, target pc+imm = 0x100.
        de          = '0;
        de.v_de     = 1'b1;
        de.alu_op   = ALU_ADD;
        de.funct3   = F3_BEQ;
        de.use_pc   = 1'b1;
        de.use_imm  = 1'b1;
        de.pc       = 32'hF0;
        de.imm      = 32'h10;
        de.rs1_data = 32'h0;
        de.rs2_data = 32'h55;
        rs1s        = SRC_WB;
        bp_wb       = 32'h55;
        #1;
        chk("beq pc_reset", 64'(pc_reset), 64'd1);
        chk("beq pc_exec", 64'(pc_exec), 64'h100);
        de.v_de = 1'b0;
        #1;
        chk("beq v_de=0 pc_reset", 64'(pc_reset), 64'd0);
        de.v_de     = 1'b1;
        de.rs2_data = 32'h56;
        #1;
        chk("beq unequal pc_reset", 64'(pc_reset), 64'd0);
        rs1s = SRC_REG;

        // JAL: redirect and link value pc+4.
        de           = '0;
        de.v_de      = 1'b1;
        de.is_jump   = 1'b1;
        de.use_pc    = 1'b1;
        de.use_imm   = 1'b1;
        de.pc        = 32'h40;
        de.imm       = 32'h20;
        de.rd        = 5'd1;
        de.reg_write = 1'b1;
        #1;
        chk("jal pc_reset", 64'(pc_reset), 64'd1);
        chk("jal pc_exec", 64'(pc_exec), 64'h60);
        tick();
        chk("jal link", 64'(ex_to_mem.alu_result), 64'h44);

        // Store killed by flush, then accepted.
        de           = '0;
        de.v_de      = 1'b1;
        de.mem_write = 1'b1;
        de.rs2_data  = 32'hCAFE;
        flush        = 1'b1;
        #1;
        chk("flush pc_reset", 64'(pc_reset), 64'd0);
        tick();
        chk("flushed store", 64'(ex_to_mem.mem_write), 64'd0);
        flush = 1'b0;
        tick();
        chk("store mem_write", 64'(ex_to_mem.mem_write), 64'd1);
        chk("store write_data", 64'(ex_to_mem.write_data), 64'hCAFE);
        de = '0;
        tick();

        // Multiply / divide vectors.
        run_md("mul",        F3_MUL,    32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 33);
        run_md("mulhu",      F3_MULHU,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 33);
        run_md("mulhu ff",   F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_md("mulh ff",    F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_md("mulhsu ff",  F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_md("div -7/2",   F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_md("rem -7/2",   F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_md("div 7/-2",   F3_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_md("rem 7/-2",   F3_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33);
        run_md("divu 100/7", F3_DIVU,   32'd100,       32'd7,         32'd14,        33);
        run_md("remu 100/7", F3_REMU,   32'd100,       32'd7,         32'd2,         33);
        run_md("divu x/0",   F3_DIVU,   32'h1234,      32'd0,         32'hFFFF_FFFF, 2);
        run_md("remu x/0",   F3_REMU,   32'h1234,      32'd0,         32'h1234,      2);
        run_md("div ovf",    F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_md("rem ovf",    F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

        // Flush on RUN cycle 10 of a DIV, then an ADD.
        de           = '0;
        de.v_de      = 1'b1;
        de.is_md     = 1'b1;
        de.funct3    = F3_DIV;
        de.rd        = 5'd9;
        de.reg_write = 1'b1;
        de.rs1_data  = 32'd100;
        de.rs2_data  = 32'd7;
        #1;
        tick();
        repeat (9) tick();
        chk("div run10 busy", 64'(ex_busy), 64'd1);
        flush = 1'b1;
        tick();
        flush        = 1'b0;
        de           = '0;
        de.v_de      = 1'b1;
        de.alu_op    = ALU_ADD;
        de.rs1_data  = 32'd1;
        de.rs2_data  = 32'd2;
        de.rd        = 5'd4;
        de.reg_write = 1'b1;
        #1;
        chk("post-flush busy", 64'(ex_busy), 64'd0);
        chk("post-flush bubble", 64'(ex_to_mem.reg_write), 64'd0);
        tick();
        chk("post-flush add", {ex_to_mem.alu_result, ex_to_mem.rd, ex_to_mem.reg_write},
            {32'd3, 5'd4, 1'b1});
        de = '0;
        tick();

        // Reset in the middle of a MUL.
        de           = '0;
        de.v_de      = 1'b1;
        de.is_md     = 1'b1;
        de.funct3    = F3_MUL;
        de.rd        = 5'd9;
        de.reg_write = 1'b1;
        de.rs1_data  = 32'd6;
        de.rs2_data  = 32'd7;
        #1;
        repeat (5) tick();
        chk("mul mid busy", 64'(ex_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst mid busy", 64'(ex_busy), 64'd0);
        tick();
        rst     = 1'b0;
        de.v_de = 1'b0;
        #1;
        chk("rst mid ex_to_mem", {ex_to_mem.alu_result, ex_to_mem.write_data, ex_to_mem.rd,
            ex_to_mem.funct3, ex_to_mem.mem_write, ex_to_mem.reg_write} == '0 ? 64'd1 : 64'd0, 64'd1);
        chk("rst mid busy after", 64'(ex_busy), 64'd0);
        wr_seen = 1'b0;
        for (n = 0; n < 40; n++) begin
            tick();
            if (ex_to_mem.reg_write) wr_seen = 1'b1;
        end
        chk("rst abandoned write", 64'(wr_seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_md.md
EXECUTE_MD -- requirements
Module: execute_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits (legal: 32, 64).
REQ-002 SHALL have parameter MD_ENABLE, default 1; 0 removes the multiply/divide unit, and M ops then execute as ALU ops.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port de_to_ex  input  de_to_ex_s  decoded instruction; adds field is_md, set for RV M-extension ops.
REQ-006 SHALL have ports rs1s, rs2s  input  hu_src_e  bypass select per operand: REG, MEM or WB.
REQ-007 SHALL have ports bp_mem, bp_wb  input  XLEN  bypass values from MEM and WB.
REQ-008 SHALL have port flush  input  1  kills the instruction in EX and aborts any M op.
REQ-009 SHALL have port ex_to_mem  output  ex_to_mem_s  registered result to MEM.
REQ-010 SHALL have port pc_reset  output  1  redirect request, combinational.
REQ-011 SHALL have port pc_exec  output  XLEN  redirect target, combinational.
REQ-012 SHALL have port ex_busy  output  1  combinational stall request to the hazard unit; while it is 1, de_to_ex is held stable.

Function
REQ-013 Operand selection SHALL be: MEM selects bp_mem; WB selects bp_wb; otherwise the register data. ALU input muxes use_pc and use_imm SHALL work as in the single-cycle stage.
REQ-014 For a non-M op, ex_to_mem SHALL register the result 1 cycle after EX.
  - alu_result = pc+4 on a jump, else the ALU result.
  - write_data = rs2 after bypass.
  - mem_write and reg_write are ANDed with v_de and with !flush.
REQ-015 pc_reset SHALL be (cmp && use_pc) || is_jump, gated by v_de and !flush; pc_exec SHALL be the ALU result.
REQ-016 The M-op FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE->RUN SHALL occur when v_de && is_md && !flush. On that edge both bypassed operands, funct3 and rd are latched, and the iteration counter is set to XLEN-1.
REQ-018 RUN SHALL perform one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle. It SHALL leave for DONE when the counter reaches 0.
REQ-019 DONE->IDLE SHALL occur unconditionally. In the DONE cycle, ex_to_mem SHALL register the selected result with reg_write=1 and mem_write=0.
REQ-020 ex_busy SHALL be 1 when (IDLE && v_de && is_md && !flush) or RUN; it SHALL be 0 in DONE. An M op therefore occupies EX for XLEN+2 cycles.
REQ-021 While ex_busy=1, ex_to_mem SHALL register a bubble: reg_write=0, mem_write=0.
REQ-022 funct3 SHALL select the result:
  - MUL: low XLEN bits.
  - MULH: high bits, signed x signed.
  - MULHSU: high bits, signed x unsigned.
  - MULHU: high bits, unsigned x unsigned.
  - DIV / DIVU: quotient.
  - REM / REMU: remainder.
  Signed ops SHALL take magnitudes and correct the sign at the end.
REQ-023 Divide by zero SHALL give quotient all-ones and remainder = dividend, without iterating (RUN lasts 1 cycle).
REQ-024 Signed overflow (MIN / -1) SHALL give quotient MIN and remainder 0, without iterating.
REQ-025 flush in any state SHALL force IDLE on the next edge and make ex_to_mem a bubble; a pending M result is discarded.
REQ-026 Bypass changes after the accept edge SHALL NOT affect the M result, because operands are latched.

Reset
REQ-027 While rst=1 at a clock edge:
  - FSM goes to IDLE, and the counter and operand latches clear.
  - All ex_to_mem fields are 0.
REQ-028 While rst=1, pc_reset and ex_busy SHALL be 0. Reset mid-RUN SHALL abandon the op with no write.

Structure
REQ-029 The shared package riscv_structures SHALL hold:
  - the md_state_e enum {IDLE, RUN, DONE};
  - the XLEN default constant;
  - the M funct3 constants;
  - the is_md field in de_to_ex_s.
REQ-030 The iterative unit SHALL be one sub-module, md_unit, with start/done handshake; alu and compare SHALL be reused unchanged.

Verification
REQ-031 ADD x3, rs1=5, rs2=7, rs1s=MEM, bp_mem=10 -> next cycle alu_result=17, reg_write=1, ex_busy=0.
REQ-032 MUL with 0xFFFF_FFFF x 2, XLEN=32 -> ex_busy high 33 cycles, then result 0xFFFF_FFFE; MULHU of the same operands -> 0x0000_0001.
REQ-033 DIV -7/2 -> quotient 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU x/0 -> 0xFFFF_FFFF; DIV 0x8000_0000/-1 -> 0x8000_0000.
REQ-034 flush asserted on RUN cycle 10 of a DIV -> FSM IDLE next cycle, no reg_write issued, the next ADD completes normally.
REQ-035 BEQ with equal operands (via WB bypass), use_pc=1, target 0x100 -> pc_reset=1, pc_exec=0x100; same with v_de=0 -> pc_reset=0.
REQ-036 rst asserted mid-MUL -> ex_to_mem all zero and ex_busy=0 the following cycle.
